// File: rtl/control_pkg.sv
// Shared definitions for the control sequencer: control-word layout, fixed
// words, opcode classes, opcode match patterns and sequencer FSM states.
package control_pkg;

    localparam int CW_W        = 33;
    localparam int NUM_CLASSES = 7;
    localparam int MAX_STEPS   = 4;

    // Control word field positions (single bits, or LSB of a field).
    localparam int ALU_EN         = 32;
    localparam int ALU_BS         = 31;
    localparam int ALU_FS_LSB     = 26;
    localparam int RF_B_EN        = 25;
    localparam int RF_SA_LSB      = 20;
    localparam int RF_SB_LSB      = 15;
    localparam int RF_DA_LSB      = 10;
    localparam int RF_W           = 9;
    localparam int RAM_EN         = 8;
    localparam int RAM_W          = 7;
    localparam int PC_EN          = 6;
    localparam int PC_FS_LSB      = 4;
    localparam int PC_IS          = 3;
    localparam int STATUS_LD      = 2;
    localparam int NEXT_STATE_LSB = 0;

    localparam logic [CW_W-1:0] CW_NOP =
        (CW_W'(31) << ALU_FS_LSB) |
        (CW_W'(31) << RF_SA_LSB)  |
        (CW_W'(31) << RF_SB_LSB)  |
        (CW_W'(31) << RF_DA_LSB);

    localparam logic [CW_W-1:0] CW_FETCH = CW_NOP | (CW_W'(1) << RAM_EN);

    // Fields that must not take effect while a RAM access is stalled.
    localparam logic [CW_W-1:0] CW_STALL_MASK =
        (CW_W'(1) << RF_W) | (CW_W'(1) << PC_EN) | (CW_W'(1) << STATUS_LD);

    typedef enum logic [2:0] {
        CLS_R     = 3'd0,
        CLS_I     = 3'd1,
        CLS_D     = 3'd2,
        CLS_B     = 3'd3,
        CLS_BL    = 3'd4,
        CLS_CB    = 3'd5,
        CLS_BCOND = 3'd6
    } class_e;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_FETCH,
        SEQ_EXEC,
        SEQ_HALT
    } seq_state_e;

    // Opcode match patterns, named by the instruction bits they compare.
    localparam logic [7:0]  PAT_BCOND_31_24 = 8'b01010100;
    localparam logic [5:0]  PAT_B_31_26     = 6'b000101;
    localparam logic [5:0]  PAT_BL_31_26    = 6'b100101;
    localparam logic [6:0]  PAT_CB_31_25    = 7'b1011010;
    localparam logic [10:0] PAT_LDUR_31_21  = 11'b11111000010;
    localparam logic [10:0] PAT_STUR_31_21  = 11'b11111000000;
    localparam logic [5:0]  PAT_ADDI_28_23  = 6'b100010;
    localparam logic [5:0]  PAT_ANDI_28_23  = 6'b100100;
    localparam logic [4:0]  PAT_R0_28_24    = 5'b01010;
    localparam logic [4:0]  PAT_R1_28_24    = 5'b01011;
    localparam logic [4:0]  PAT_R2_28_24    = 5'b11010;

    function automatic logic [NUM_CLASSES-1:0] class_bit(input class_e c);
        return NUM_CLASSES'(1) << c;
    endfunction

endpackage

// File: rtl/opcode_classifier.sv
// Combinational opcode classifier: maps instr[31:21] to a one-hot decoder
// class, first match wins; valid is low for unknown opcodes.
module opcode_classifier
    import control_pkg::*;
(
    input  logic [10:0]            opcode,
    output logic [NUM_CLASSES-1:0] cls_onehot,
    output logic                   valid
);

    // opcode[n] corresponds to instr[n+21].
    always_comb begin
        // NOTE: a default before the if-chain keeps this purely combinational; any path that skipped an assignment would infer a latch.
        cls_onehot = '0;
        if (opcode[10:3] == PAT_BCOND_31_24) begin
            cls_onehot = class_bit(CLS_BCOND);
        end else if (opcode[10:5] == PAT_B_31_26) begin
            cls_onehot = class_bit(CLS_B);
        end else if (opcode[10:5] == PAT_BL_31_26) begin
            cls_onehot = class_bit(CLS_BL);
        end else if (opcode[10:4] == PAT_CB_31_25) begin
            cls_onehot = class_bit(CLS_CB);
        end else if (opcode == PAT_LDUR_31_21 || opcode == PAT_STUR_31_21) begin
            cls_onehot = class_bit(CLS_D);
        end else if (opcode[7:2] == PAT_ADDI_28_23 || opcode[7:2] == PAT_ANDI_28_23) begin
            cls_onehot = class_bit(CLS_I);
        end else if (opcode[7:3] == PAT_R0_28_24 || opcode[7:3] == PAT_R1_28_24 ||
                     opcode[7:3] == PAT_R2_28_24) begin
            cls_onehot = class_bit(CLS_R);
        end
    end

    assign valid = |cls_onehot;

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: fetches an instruction, then applies the
// selected decoder control word once per micro-step, stalling on RAM.
module control_sequencer #(
    parameter int NCLS = 7,
    parameter int CW_W = 33
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [31:0]          data_in,
    input  logic                 mem_ready,
    input  logic [4:0]           alu_status,
    input  logic [NCLS*CW_W-1:0] cw_bus,
    output logic [31:0]          instr,
    output logic [1:0]           state,
    output logic [4:0]           status,
    output logic [CW_W-1:0]      cw,
    output logic                 halted
);

    import control_pkg::*;

    seq_state_e             fsm;
    logic [2:0]             step_cnt;
    logic [NUM_CLASSES-1:0] cls_onehot;
    logic                   cls_valid;
    logic [CW_W-1:0]        sel_word;
    logic [1:0]             next_step;
    logic                   in_exec;
    logic                   stall;
    logic                   commit;
    logic                   watchdog_trip;

    opcode_classifier u_classifier (
        .opcode     (instr[31:21]),
        .cls_onehot (cls_onehot),
        .valid      (cls_valid)
    );

    always_comb begin
        sel_word = '0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            if (cls_onehot[k]) begin
                sel_word = sel_word | cw_bus[k*CW_W +: CW_W];
            end
        end
    end

    assign next_step     = sel_word[NEXT_STATE_LSB +: 2];
    assign in_exec       = (fsm == SEQ_EXEC) && cls_valid;
    assign stall         = in_exec && sel_word[RAM_EN] && !mem_ready;
    assign commit        = in_exec && !stall;
    // A commit that would begin micro-step MAX_STEPS+1 is treated as a runaway.
    assign watchdog_trip = (next_step != 2'd0) && (step_cnt == 3'(MAX_STEPS - 1));

    always_comb begin
        cw = CW_NOP;
        unique case (fsm)
            SEQ_IDLE:  cw = CW_NOP;
            SEQ_FETCH: cw = CW_FETCH;
            SEQ_EXEC: begin
                if (!cls_valid) begin
                    cw = CW_NOP;
                end else if (stall) begin
                    cw = sel_word & ~CW_STALL_MASK;
                end else begin
                    cw = sel_word;
                end
            end
            SEQ_HALT:  cw = CW_NOP;
            default:   cw = CW_NOP;
        endcase
    end

    // NOTE: every register here has a defined reset value so an aborted instruction leaves nothing half-committed.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fsm      <= SEQ_IDLE;
            instr    <= '0;
            state    <= '0;
            status   <= '0;
            step_cnt <= '0;
            halted   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values, independent of statement order.
            unique case (fsm)
                SEQ_IDLE: begin
                    if (start) begin
                        fsm <= SEQ_FETCH;
                    end
                end
                SEQ_FETCH: begin
                    if (mem_ready) begin
                        instr    <= data_in;
                        state    <= 2'd0;
                        step_cnt <= '0;
                        fsm      <= SEQ_EXEC;
                    end
                end
                SEQ_EXEC: begin
                    if (!cls_valid) begin
                        fsm    <= SEQ_HALT;
                        halted <= 1'b1;
                    end else if (commit) begin
                        if (watchdog_trip) begin
                            fsm    <= SEQ_HALT;
                            halted <= 1'b1;
                        end else begin
                            if (sel_word[STATUS_LD]) begin
                                status <= alu_status;
                            end
                            state <= next_step;
                            if (next_step == 2'd0) begin
                                fsm <= SEQ_FETCH;
                            end else begin
                                step_cnt <= step_cnt + 3'd1;
                            end
                        end
                    end
                end
                SEQ_HALT: begin
                    fsm <= SEQ_HALT;
                end
                default: begin
                    fsm <= SEQ_HALT;
                end
            endcase
        end
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Multi-cycle sequencer for the control unit. It owns the instruction register, the micro-step state, and the status register that feed every instruction-class decoder. It picks the decoder control word for the current opcode class and applies it to the datapath (ALU, register file, RAM, PC) cycle by cycle. A `mem_ready` handshake lets RAM accesses stall, and unknown opcodes halt the sequencer.

## Interface
- `NCLS`, default 7: number of decoder classes on `cw_bus`.
- `CW_W`, default 33: control word width.
- `clock`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  level; leaves IDLE.
- `data_in`  in  32  databus value; holds the instruction during FETCH.
- `mem_ready`  in  1  RAM has completed the current access this cycle.
- `alu_status`  in  5  flags from the ALU.
- `cw_bus`  in  NCLS*CW_W  decoder control words; class k occupies bits [k*CW_W +: CW_W].
- `instr`  out  32  instruction register; drives the `I` input of all decoders.
- `state`  out  2  micro-step; drives the `state` input of all decoders.
- `status`  out  5  registered flags; drives the `status` input of all decoders.
- `cw`  out  CW_W  applied control word.
- `halted`  out  1  sticky; cleared only by reset.

## Operation
- Control word fields, MSB first:
  - [32] alu_en
  - [31] alu_bs
  - [30:26] alu_fs
  - [25] rf_b_en
  - [24:20] rf_sa
  - [19:15] rf_sb
  - [14:10] rf_da
  - [9] rf_w
  - [8] ram_en
  - [7] ram_w
  - [6] pc_en
  - [5:4] pc_fs
  - [3] pc_is
  - [2] status_ld
  - [1:0] next_state
- NOP word: alu_fs=11111, rf_sa/rf_sb/rf_da=31, pc_fs=00, every other field 0.
- FETCH word: NOP with ram_en=1. The PC is not advanced in FETCH; the decoders own all PC updates.
- FSM states:
  - IDLE: `cw`=NOP. Go to FETCH when `start`=1.
  - FETCH: `cw`=FETCH word. When `mem_ready`=1: latch `instr`←`data_in`, set `state`←0, step count←0, go to EXEC. Otherwise stay in FETCH.
  - EXEC: classify `instr`.
    - No class matches: go to HALT; `cw`=NOP this cycle.
    - Otherwise `cw` = the selected class word.
    - Commit when the word's ram_en=0, or when `mem_ready`=1.
    - On commit: if status_ld=1, `status`←`alu_status`. Then `state`←next_state. If next_state=0, go to FETCH; otherwise stay in EXEC.
  - HALT: `cw`=NOP, `halted`=1, absorbing.
- Stall (EXEC, ram_en=1, `mem_ready`=0):
  - Output the selected word with rf_w, pc_en and status_ld forced to 0; ram_en and ram_w pass through unchanged.
  - `state`, `status` and step count hold.
- Watchdog: if a commit in EXEC would start a fifth micro-step (step count reaches 4 with next_state≠0), go to HALT.
- Classification on `instr[31:21]`, first match wins, in this order:
  - B.cond (class 6): [31:24]=01010100
  - B (class 3): [31:26]=000101
  - BL (class 4): [31:26]=100101
  - CBZ/CBNZ (class 5): [31:25]=1011010
  - D (class 2): [31:21]=11111000010 or 11111000000
  - I (class 1): [28:23]=100010 or 100100
  - R (class 0): [28:24]=01010, 01011 or 11010
- `start` is ignored outside IDLE.

## Timing
- Reset values: FSM=IDLE, `cw`=NOP, `instr`=0, `state`=0, `status`=0, `halted`=0, step count=0.
- `instr`, `state`, `status`, FSM state and step count are registered.
- `cw` is combinational from registered state, `instr` and `cw_bus`, and is valid in the same cycle.
- `mem_ready` is sampled at the rising edge.
- Minimum instruction time with no stalls: 1 FETCH cycle plus N EXEC cycles, where N = micro-steps.
- Reset asserted mid-instruction aborts immediately to reset values; no partial commit.

## Structure
- Package `control_pkg`:
  - control word field position constants
  - CW_W
  - NOP and FETCH words
  - class index enum
  - opcode match patterns
  - FSM state enum
- Sub-module `opcode_classifier`: combinational; `instr` in, one-hot class plus `valid` out.

## Test plan
- Reset, then `start`=1, `data_in`=BL 0x94000010 with `mem_ready`=1 → FETCH for 1 cycle, then EXEC with `cw`=class-4 word, `state`=0, then back to FETCH.
- D-type LDUR 0xF8400000; class-2 word has ram_en=1 and next_state=0; `mem_ready` low for 3 cycles → `cw` rf_w=0 and `state` held during the stall; commit on the 4th cycle.
- R-type ADD 0x8B020020; class-0 word has status_ld=1 and next_state=01, then 00; `alu_status`=5'b10101 → `status`=10101 after the first commit; exactly 2 EXEC cycles.
- Illegal opcode 0x00000000 → HALT in the first EXEC cycle, `halted`=1, `cw`=NOP; further `start` pulses have no effect.
- Class word with next_state permanently 01 → HALT on the commit that would start a fifth micro-step.
- Reset pulsed low during a stalled EXEC → all outputs return to reset values asynchronously; `status` unchanged by the aborted word.
